// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame arbiter state encoding and default frame geometry,
// also used by slave-side benches.
package spi_pkg;

    localparam int SPI_WIDTH = 16;
    localparam int SPI_GAP   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/spi_frame_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to the
// requester that did not own the last frame.
module rr_arb2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_owner,
    output logic o_valid,
    output logic o_idx
);

    assign o_valid = i_req0 | i_req1;
    assign o_idx   = (i_req0 & i_req1) ? ~i_last_owner : i_req1;

endmodule

// File: rtl/spi_frame_arbiter.sv
// Arbitrates two word requesters onto one SPI slave: LSB-first frames of WIDTH bits,
// separated by at least GAP chip-select-high cycles.
module spi_frame_arbiter
    import spi_pkg::*;
#(
    parameter int WIDTH = SPI_WIDTH,
    parameter int GAP   = SPI_GAP
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             ack0,
    output logic             ack1,
    output logic             cs,
    output logic             mosi,
    output logic             busy,
    output logic             owner,
    output logic             done
);

    localparam int                 CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [3:0]         GAP_LOAD = 4'(GAP);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_shift, w_shift_nxt;
    logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [3:0]       r_gap_cnt, w_gap_cnt_nxt;
    logic             r_cs, w_cs_nxt;
    logic             r_mosi, w_mosi_nxt;
    logic             r_ack0, w_ack0_nxt;
    logic             r_ack1, w_ack1_nxt;
    logic             r_done, w_done_nxt;
    logic             r_owner, w_owner_nxt;

    logic             w_grant_valid;
    logic             w_grant_idx;
    logic             w_can_grant;
    logic [WIDTH-1:0] w_payload;

    rr_arb2 u_arb (
        .i_req0       (req0),
        .i_req1       (req1),
        .i_last_owner (r_owner),
        .o_valid      (w_grant_valid),
        .o_idx        (w_grant_idx)
    );

    // The last GAP cycle decides like IDLE, so a held request sees exactly GAP cs-high cycles.
    assign w_can_grant = (r_state == ST_IDLE) || ((r_state == ST_GAP) && (r_gap_cnt <= 4'd1));
    assign w_payload   = w_grant_idx ? data1 : data0;

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_cs_nxt      = r_cs;
        w_mosi_nxt    = r_mosi;
        w_owner_nxt   = r_owner;
        w_ack0_nxt    = 1'b0;
        w_ack1_nxt    = 1'b0;
        w_done_nxt    = 1'b0;

        case (r_state)
            ST_SHIFT: begin
                if (r_bit_cnt == LAST_BIT) begin
                    w_state_nxt   = ST_GAP;
                    w_cs_nxt      = 1'b1;
                    w_mosi_nxt    = 1'b0;
                    w_done_nxt    = 1'b1;
                    w_gap_cnt_nxt = GAP_LOAD;
                    w_bit_cnt_nxt = '0;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    w_mosi_nxt    = r_shift[0];
                    w_shift_nxt   = r_shift >> 1;
                end
            end
            ST_GAP: begin
                w_gap_cnt_nxt = r_gap_cnt - 4'd1;
                if (r_gap_cnt <= 4'd1) begin
                    w_state_nxt   = ST_IDLE;
                    w_gap_cnt_nxt = '0;
                end
            end
            default: begin
                w_cs_nxt   = 1'b1;
                w_mosi_nxt = 1'b0;
            end
        endcase

        if (w_can_grant && w_grant_valid) begin
            w_state_nxt   = ST_SHIFT;
            w_owner_nxt   = w_grant_idx;
            w_ack0_nxt    = ~w_grant_idx;
            w_ack1_nxt    = w_grant_idx;
            w_cs_nxt      = 1'b0;
            w_mosi_nxt    = w_payload[0];
            w_shift_nxt   = w_payload >> 1;
            w_bit_cnt_nxt = '0;
            w_gap_cnt_nxt = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments only; the combinational block above
    // owns every next-state decision so this process stays a plain register bank.
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_cs      <= 1'b1;
            r_mosi    <= 1'b0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_done    <= 1'b0;
            r_owner   <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_cs      <= w_cs_nxt;
            r_mosi    <= w_mosi_nxt;
            r_ack0    <= w_ack0_nxt;
            r_ack1    <= w_ack1_nxt;
            r_done    <= w_done_nxt;
            r_owner   <= w_owner_nxt;
        end
    end

    assign ack0  = r_ack0;
    assign ack1  = r_ack1;
    assign cs    = r_cs;
    assign mosi  = r_mosi;
    assign done  = r_done;
    assign owner = r_owner;
    assign busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_frame_arbiter.sv
// Bench for spi_frame_arbiter: a timestamp-based frame model plus a serial slave
// model, driven by directed scenarios and a randomized requester phase.
module tb_spi_frame_arbiter;

    localparam int W = 16;
    localparam int G = 2;

    logic         sclk = 1'b0;
    logic         rst  = 1'b1;
    logic         req0 = 1'b0;
    logic         req1 = 1'b0;
    logic [W-1:0] data0 = '0;
    logic [W-1:0] data1 = '0;
    logic         ack0, ack1, cs, mosi, busy, owner, done;

    spi_frame_arbiter #(.WIDTH(W), .GAP(G)) dut (
        .sclk  (sclk),
        .rst   (rst),
        .req0  (req0),
        .req1  (req1),
        .data0 (data0),
        .data1 (data1),
        .ack0  (ack0),
        .ack1  (ack1),
        .cs    (cs),
        .mosi  (mosi),
        .busy  (busy),
        .owner (owner),
        .done  (done)
    );

    always #5 sclk = ~sclk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a frame is a start cycle plus payload; grants are allowed from
    // the cycle stamped in 'earliest' onward.
    int           cyc      = 0;
    int           earliest = 0;
    int           f_start  = 0;
    bit           in_frame = 1'b0;
    bit           m_owner  = 1'b1;
    bit           m_rst    = 1'b0;
    logic [W-1:0] f_data    = '0;
    logic [W-1:0] done_word = '0;
    bit e_cs = 1'b1, e_mosi = 1'b0, e_ack0 = 1'b0, e_ack1 = 1'b0, e_done = 1'b0, e_busy = 1'b0;

    // Slave model and per-scenario statistics taken from the DUT pins.
    logic [W-1:0] slave_word = '0;
    int           slave_bit  = 0;
    logic [W-1:0] q_cap[$];
    int n_cs_low = 0, n_done = 0, n_ack0 = 0, n_ack1 = 0;
    int ack0_cyc = 0, ack1_cyc = 0;
    bit auto_drop0 = 1'b1, auto_drop1 = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge();
        bit idx;
        cyc++;
        m_rst  = rst;
        e_ack0 = 1'b0;
        e_ack1 = 1'b0;
        e_done = 1'b0;
        if (rst) begin
            in_frame = 1'b0;
            m_owner  = 1'b1;
            earliest = cyc;
        end else begin
            if (in_frame && cyc == f_start + W) begin
                in_frame  = 1'b0;
                e_done    = 1'b1;
                done_word = f_data;
                earliest  = cyc + G;
            end
            if (!in_frame && cyc >= earliest && (req0 || req1)) begin
                idx      = (req0 && req1) ? !m_owner : req1;
                m_owner  = idx;
                f_start  = cyc;
                f_data   = idx ? data1 : data0;
                in_frame = 1'b1;
                e_ack0   = !idx;
                e_ack1   = idx;
            end
        end
        e_cs   = !in_frame;
        e_mosi = in_frame ? f_data[cyc - f_start] : 1'b0;
        e_busy = in_frame || (cyc < earliest);
    endtask

    task automatic observe();
        check("cs", cs, e_cs);
        check("mosi", mosi, e_mosi);
        check("ack0", ack0, e_ack0);
        check("ack1", ack1, e_ack1);
        check("done", done, e_done);
        check("busy", busy, e_busy);
        check("owner", owner, m_owner);
        if (ack0) begin n_ack0++; ack0_cyc = cyc; end
        if (ack1) begin n_ack1++; ack1_cyc = cyc; end
        if (m_rst) begin
            slave_word = '0;
            slave_bit  = 0;
        end else begin
            if (!cs) begin
                if (slave_bit < W) slave_word[slave_bit] = mosi;
                slave_bit++;
                n_cs_low++;
            end
            if (done) begin
                check("frame_bits", slave_bit, W);
                check("frame_word", slave_word, done_word);
                q_cap.push_back(slave_word);
                slave_word = '0;
                slave_bit  = 0;
                n_done++;
            end
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        model_edge();
        @(negedge sclk);
        observe();
        if (auto_drop0 && e_ack0) req0 = 1'b0;
        if (auto_drop1 && e_ack1) req1 = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_stats();
        n_cs_low = 0;
        n_done   = 0;
        n_ack0   = 0;
        n_ack1   = 0;
    endtask

    initial begin
        // Reset state.
        rst = 1'b1;
        ticks(3);
        rst = 1'b0;

        // Single requester, known payload.
        clear_stats();
        req0  = 1'b1;
        data0 = 16'hA5C3;
        ticks(30);
        check("single_ack0", n_ack0, 1);
        check("single_cs_low", n_cs_low, 16);
        check("single_done", n_done, 1);
        check("single_word", q_cap[$], 16'hA5C3);

        // Quiet bus.
        clear_stats();
        ticks(100);
        check("quiet_cs_low", n_cs_low, 0);
        check("quiet_done", n_done, 0);
        check("quiet_acks", n_ack0 + n_ack1, 0);

        // Both requesters held from reset: alternating back-to-back frames.
        rst        = 1'b1;
        req0       = 1'b1;
        req1       = 1'b1;
        data0      = 16'h1111;
        data1      = 16'h2222;
        auto_drop0 = 1'b0;
        auto_drop1 = 1'b0;
        ticks(2);
        rst = 1'b0;
        q_cap.delete();
        ticks(3 * (W + G) + 2);
        check("rr_count", q_cap.size() >= 3, 1);
        if (q_cap.size() >= 3) begin
            check("rr_frame0", q_cap[0], 16'h1111);
            check("rr_frame1", q_cap[1], 16'h2222);
            check("rr_frame2", q_cap[2], 16'h1111);
        end
        req0       = 1'b0;
        req1       = 1'b0;
        auto_drop0 = 1'b1;
        auto_drop1 = 1'b1;
        ticks(W + G + 4);

        // Reset in the middle of a frame, request held across it.
        clear_stats();
        req0       = 1'b1;
        data0      = 16'h5A3C;
        auto_drop0 = 1'b0;
        ticks(8);
        rst = 1'b1;
        tick();
        check("abort_cs", cs, 1'b1);
        check("abort_no_done", n_done, 0);
        rst        = 1'b0;
        auto_drop0 = 1'b1;
        ticks(W + 4);
        check("abort_regrant_done", n_done, 1);
        check("abort_regrant_word", q_cap[$], 16'h5A3C);
        ticks(G + 2);

        // Payload change after ack and a late second requester.
        clear_stats();
        req0  = 1'b1;
        data0 = 16'h1234;
        tick();
        data0 = 16'hFFFF;
        ticks(5);
        req1  = 1'b1;
        data1 = 16'hBEEF;
        ticks(30);
        check("late_ack1", n_ack1, 1);
        check("late_ack1_delay", ack1_cyc - ack0_cyc, W + G);
        check("hold_payload", q_cap[$-1], 16'h1234);
        check("late_word", q_cap[$], 16'hBEEF);

        // Randomized requesters with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 149) == 0);
            auto_drop0 = $urandom_range(0, 1);
            auto_drop1 = $urandom_range(0, 1);
            if (!req0 && $urandom_range(0, 3) == 0) begin
                req0  = 1'b1;
                data0 = W'($urandom);
            end
            if (!req1 && $urandom_range(0, 3) == 0) begin
                req1  = 1'b1;
                data1 = W'($urandom);
            end
            tick();
            if (e_ack0) data0 = W'($urandom);
            if (e_ack1) data1 = W'($urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
